vga_capture: RTL and testbench

- Receiving end of the video interface that the VGA timing generator drives. Consumes hsync, vsync, data_enable and RGB.
- Recovers pixel coordinates from the sync and enable signals, samples the centre pixel of every cell, and decodes it to a live/dead bit.
- Emits one cell-memory write per cell per frame. Used for loopback self-check of the Game-of-life display path and for capturing board images from an external video source.

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_if.sv | 11 +
 rtl/vga_cell_sampler.sv | 54 +++++
 rtl/vga_capture.sv | 90 +++++++++
 tb/tb_vga_capture.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: FSM states and video timing constants shared by the capture block and the timing generator
package vga_pkg;
  typedef enum logic [1:0] {SEEK, VBLANK, FRAME, DONE} state_t;
  localparam int HSIZE = 800;
  localparam int HFP = 40;
  localparam int HSP = 128;
  localparam int HMAX = 1056;
  localparam int VSIZE = 600;
  localparam int VFP = 1;
  localparam int VSP = 4;
  localparam int VMAX = 628;
  localparam int P_PARAM_N = 40;
  localparam int P_PARAM_M = 30;
endpackage

// File: rtl/vga_if.sv
// vga_if: sync, enable and RGB signals between a video source and a video sink
interface vga_if;
  logic hsync;
  logic vsync;
  logic data_enable;
  logic [7:0] video_red;
  logic [7:0] video_green;
  logic [7:0] video_blue;
  modport source (output hsync, vsync, data_enable, video_red, video_green, video_blue);
  modport sink (input hsync, vsync, data_enable, video_red, video_green, video_blue);
endinterface

// File: rtl/vga_cell_sampler.sv
// vga_cell_sampler: pixel/line/cell counters and the cell-centre sample strobe
module vga_cell_sampler #(
  parameter int WIDTH = 12,
  parameter int PIXIV = 20,
  parameter int NCOL = 40,
  parameter int NROW = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic de,
  input  logic clr,
  output logic sample,
  output logic rise,
  output logic fall,
  output logic [WIDTH-1:0] px,
  output logic [WIDTH-1:0] line,
  output logic [WIDTH-1:0] col,
  output logic [WIDTH-1:0] row
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(PIXIV - 1);
  localparam logic [WIDTH-1:0] MID = WIDTH'(PIXIV / 2);
  localparam logic [WIDTH-1:0] NC = WIDTH'(NCOL);
  localparam logic [WIDTH-1:0] NR = WIDTH'(NROW);
  logic [WIDTH-1:0] colsub, rowsub;
  logic de_q;
  assign rise = de & ~de_q;
  assign fall = ~de & de_q;
  // col/row bounds keep over-long lines or frames from producing out-of-range writes
  assign sample = de && colsub == MID && rowsub == MID && col < NC && row < NR;
  always_ff @(posedge clk)
    if (rst) begin
      de_q <= 1'b0;
      px <= '0;
      colsub <= '0;
      col <= '0;
      line <= '0;
      rowsub <= '0;
      row <= '0;
    end else begin
      de_q <= de;
      px <= de ? px + WIDTH'(px != '1) : '0;
      colsub <= de && colsub != LAST ? colsub + 1'b1 : '0;
      col <= de ? col + WIDTH'(colsub == LAST && col != '1) : '0;
      if (clr) begin
        line <= '0;
        rowsub <= '0;
        row <= '0;
      end else if (fall) begin
        line <= line + WIDTH'(line != '1);
        rowsub <= rowsub == LAST ? '0 : rowsub + 1'b1;
        row <= row + WIDTH'(rowsub == LAST && row != '1);
      end
    end
endmodule

// File: rtl/vga_capture.sv
// vga_capture: recovers cell coordinates from a VGA stream and emits one live/dead write per cell per frame
module vga_capture
  import vga_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int HSIZE = vga_pkg::HSIZE,
  parameter int VSIZE = vga_pkg::VSIZE,
  parameter int HSPP = 1,
  parameter int VSPP = 1,
  parameter int P_PARAM_N = vga_pkg::P_PARAM_N,
  parameter int P_PARAM_M = vga_pkg::P_PARAM_M
) (
  input  logic clk,
  input  logic rst,
  vga_if.sink vid,
  output logic wr_en,
  output logic [2*WIDTH-1:0] wr_addr,
  output logic wr_live,
  output logic frame_done,
  output logic locked,
  output logic err
);
  localparam int AW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] HSZ = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0] VSZ = WIDTH'(VSIZE);
  state_t state, state_n;
  logic sample, rise, fall, clr, err_c, extra, frame_err, vs_act, hs_act;
  logic [WIDTH-1:0] px, line, col, row, line_n;
  vga_cell_sampler #(
    .WIDTH(WIDTH), .PIXIV(HSIZE / P_PARAM_N), .NCOL(P_PARAM_N), .NROW(P_PARAM_M)
  ) u_sampler (
    .clk, .rst, .de(vid.data_enable), .clr, .sample, .rise, .fall, .px, .line, .col, .row
  );
  assign vs_act = vid.vsync == 1'(VSPP);
  assign hs_act = vid.hsync == 1'(HSPP);
  // a line ending on this cycle is counted before the vsync rule is applied
  assign line_n = line + WIDTH'(fall);
  assign extra = rise && line == VSZ;
  always_ff @(posedge clk) state <= rst ? SEEK : state_n;
  always_comb begin
    state_n = state;
    err_c = hs_act && vid.data_enable;
    clr = 1'b0;
    case (state)
      SEEK: begin
        err_c |= extra;
        state_n = vs_act ? VBLANK : SEEK;
      end
      VBLANK: begin
        clr = !vs_act;
        state_n = vs_act ? VBLANK : FRAME;
      end
      FRAME: begin
        err_c |= fall && px != HSZ;
        if (extra) begin
          err_c = 1'b1;
          state_n = SEEK;
        end else if (line_n == VSZ) state_n = DONE;
        else if (vs_act) begin
          err_c = 1'b1;
          state_n = VBLANK;
        end
      end
      DONE: begin
        err_c |= extra;
        state_n = SEEK;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_live <= 1'b0;
      frame_done <= 1'b0;
      locked <= 1'b0;
      err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_en <= state == FRAME && sample;
      if (sample) begin
        wr_addr <= AW'(row) * AW'(P_PARAM_N) + AW'(col);
        wr_live <= |{vid.video_red, vid.video_green, vid.video_blue};
      end
      frame_done <= state == DONE;
      err <= err_c;
      frame_err <= !clr && (frame_err || err_c);
      locked <= !err_c && (locked || (state == DONE && !frame_err));
    end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scenario table of frames on a scaled 40x40 screen, positive- and negative-polarity DUTs side by side
module tb_vga_capture;
  localparam int W = 12, H = 40, V = 40, N = 4, M = 4, P = 10, HB = 6, AW = 2 * W;
  typedef struct packed {logic [AW-1:0] addr; logic live;} wr_t;
  typedef struct {
    int board; int short_y; int abort_y; int rst_y; int hs_y; bit extra;
    int exp_wr; int exp_done; int exp_err; bit exp_lock;
  } scen_t;
  typedef struct {logic [23:0] rgb; bit live;} dec_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  vga_if va();
  vga_if vb();
  logic [1:0] we, wl, fd, lk, er;
  logic [AW-1:0] wa [2];
  vga_capture #(.WIDTH(W), .HSIZE(H), .VSIZE(V), .HSPP(1), .VSPP(1), .P_PARAM_N(N), .P_PARAM_M(M)) dut_a (
    .clk(clk), .rst(rst), .vid(va), .wr_en(we[0]), .wr_addr(wa[0]), .wr_live(wl[0]),
    .frame_done(fd[0]), .locked(lk[0]), .err(er[0]));
  vga_capture #(.WIDTH(W), .HSIZE(H), .VSIZE(V), .HSPP(0), .VSPP(0), .P_PARAM_N(N), .P_PARAM_M(M)) dut_b (
    .clk(clk), .rst(rst), .vid(vb), .wr_en(we[1]), .wr_addr(wa[1]), .wr_live(wl[1]),
    .frame_done(fd[1]), .locked(lk[1]), .err(er[1]));
  int tests = 0, fails = 0;
  wr_t exp_w [64];
  int n_exp;
  wr_t act_w [2][64];
  int n_act [2], done_cnt [2], err_cnt [2], ovl [2];
  logic [23:0] cell_col [N*M];
  bit cell_live [N*M];
  bit cap;
  scen_t tbl [12];
  dec_t dec [4];
  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, d, got, want);
    end
  endtask
  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      if (we[d] && n_act[d] < 64) begin
        act_w[d][n_act[d]] = '{wa[d], wl[d]};
        n_act[d]++;
      end
      if (fd[d]) done_cnt[d]++;
      if (er[d]) err_cnt[d]++;
      if (fd[d] && we[d]) ovl[d]++;
    end
  task automatic drive(input bit de, input bit hs, input bit vs, input logic [23:0] c);
    va.data_enable = de; va.hsync = hs; va.vsync = vs;
    {va.video_red, va.video_green, va.video_blue} = c;
    vb.data_enable = de; vb.hsync = ~hs; vb.vsync = ~vs;
    {vb.video_red, vb.video_green, vb.video_blue} = c;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_wr_en"}, d, 32'(we[d]), 0);
      chk({tag, "_wr_addr"}, d, 32'(wa[d]), 0);
      chk({tag, "_wr_live"}, d, 32'(wl[d]), 0);
      chk({tag, "_frame_done"}, d, 32'(fd[d]), 0);
      chk({tag, "_locked"}, d, 32'(lk[d]), 0);
      chk({tag, "_err"}, d, 32'(er[d]), 0);
    end
  endtask
  // every cell's colour sits on its centre pixel only; all other visible pixels carry random noise
  task automatic do_line(input int y, input int len, input bit vs, input bit glitch, input bit rst_here);
    bit d, ctr, hs;
    logic [23:0] c;
    int a;
    for (int x = 0; x < H + HB; x++) begin
      d = x < len;
      ctr = d && y >= 0 && y < V && (x % P) == P / 2 && (y % P) == P / 2;
      a = ctr ? (y / P) * N + x / P : 0;
      hs = (x >= H + 2 && x < H + 4) || (glitch && x == 10);
      c = !d ? 24'h0 : ctr ? cell_col[a] : 24'($urandom);
      if (ctr && cap && n_exp < 64) begin
        exp_w[n_exp] = '{AW'(a), cell_live[a]};
        n_exp++;
      end
      rst = rst_here && x == H / 2;
      drive(d, hs, vs, c);
      if (rst) begin
        chk_zero("midrst");
        rst = 0;
        cap = 0;
      end
    end
  endtask
  task automatic do_frame(input int idx, input scen_t s);
    logic [23:0] c;
    n_exp = 0;
    cap = 1;
    for (int d = 0; d < 2; d++) begin
      n_act[d] = 0; done_cnt[d] = 0; err_cnt[d] = 0; ovl[d] = 0;
    end
    for (int a = 0; a < N * M; a++) begin
      case (s.board)
        1: cell_live[a] = ((a / N) + (a % N)) % 2 == 1;
        2: cell_live[a] = 1;
        default: cell_live[a] = $urandom_range(1);
      endcase
      c = 24'($urandom);
      if (c == 0) c = 24'h800000;
      cell_col[a] = cell_live[a] ? c : 24'h0;
    end
    if (s.board == 3)
      for (int i = 0; i < 4; i++) begin
        cell_col[5 + i] = dec[i].rgb;
        cell_live[5 + i] = dec[i].live;
      end
    do_line(-1, 0, 0, 0, 0);
    for (int y = 0; y < V; y++) begin
      do_line(y, y == s.short_y ? H - 1 : H, 0, y == s.hs_y, y == s.rst_y);
      if (y == s.abort_y) break;
    end
    if (s.abort_y < 0) begin
      if (s.extra) do_line(V, H, 0, 0, 0);
      do_line(-1, 0, 0, 0, 0);
    end
    do_line(-1, 0, 1, 0, 0);
    do_line(-1, 0, 1, 0, 0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("f%0d_wr_count", idx), d, n_act[d], s.exp_wr);
      for (int i = 0; i < n_act[d] && i < n_exp; i++) begin
        chk($sformatf("f%0d_wr_addr%0d", idx, i), d, 32'(act_w[d][i].addr), 32'(exp_w[i].addr));
        chk($sformatf("f%0d_wr_live%0d", idx, i), d, 32'(act_w[d][i].live), 32'(exp_w[i].live));
      end
      chk($sformatf("f%0d_frame_done", idx), d, done_cnt[d], s.exp_done);
      chk($sformatf("f%0d_err", idx), d, err_cnt[d], s.exp_err);
      chk($sformatf("f%0d_locked", idx), d, 32'(lk[d]), 32'(s.exp_lock));
      chk($sformatf("f%0d_done_overlap", idx), d, ovl[d], 0);
    end
  endtask
  initial begin
    dec[0] = '{24'hFF0000, 1'b1};
    dec[1] = '{24'h0000FF, 1'b1};
    dec[2] = '{24'h000100, 1'b1};
    dec[3] = '{24'h000000, 1'b0};
    //          board short abort rst  hs extra wr done err lock
    tbl[0]  = '{1, -1, -1, -1, -1, 1'b0, 16, 1, 0, 1'b1};
    tbl[1]  = '{2, -1, -1, -1, -1, 1'b0, 16, 1, 0, 1'b1};
    tbl[2]  = '{0, 15, -1, -1, -1, 1'b0, 16, 1, 1, 1'b0};
    tbl[3]  = '{0, -1, -1, -1, -1, 1'b0, 16, 1, 0, 1'b1};
    tbl[4]  = '{0, -1, 25, -1, -1, 1'b0, 12, 0, 1, 1'b0};
    tbl[5]  = '{3, -1, -1, -1, -1, 1'b0, 16, 1, 0, 1'b1};
    tbl[6]  = '{0, -1, -1, 15, -1, 1'b0, 6, 0, 0, 1'b0};
    tbl[7]  = '{1, -1, -1, -1, -1, 1'b0, 16, 1, 0, 1'b1};
    tbl[8]  = '{0, -1, -1, -1, 7, 1'b0, 16, 1, 1, 1'b0};
    tbl[9]  = '{0, -1, -1, -1, -1, 1'b0, 16, 1, 0, 1'b1};
    tbl[10] = '{0, -1, -1, -1, -1, 1'b1, 16, 1, 1, 1'b0};
    tbl[11] = '{3, -1, -1, -1, -1, 1'b0, 16, 1, 0, 1'b1};
    cap = 0;
    n_exp = 0;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 24'h0);
    chk_zero("reset");
    rst = 0;
    drive(0, 0, 0, 24'h0);
    do_line(-1, 0, 1, 0, 0);
    do_line(-1, 0, 1, 0, 0);
    for (int i = 0; i < 12; i++) do_frame(i, tbl[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
